// File: rtl/neighbor_scan_ctrl_pkg.sv
// Shared definitions for the neighbor scan controller: coordinate width,
// fixed-point unit constants and the sequencer state encoding.
package neighbor_scan_ctrl_pkg;

  localparam int QWIDTH = 32;

  localparam logic [31:0] Q16_ONE = 32'h0001_0000;
  localparam logic [63:0] Q32_ONE = 64'h0000_0001_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_I = 3'd1,
    ST_LATCH_I = 3'd2,
    ST_FETCH_J = 3'd3,
    ST_EVAL    = 3'd4,
    ST_EMIT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/neighbor_scan_ctrl_dist_sq.sv
// Squared distance of two Q16.16 points, returned as unsigned Q32.32.
// Differences wrap at W bits; each square is at most 2^(2W-2), so the sum fits in 2W bits.
module neighbor_scan_ctrl_dist_sq #(
  parameter int W = neighbor_scan_ctrl_pkg::QWIDTH
) (
  input  logic signed [W-1:0]   xi,
  input  logic signed [W-1:0]   yi,
  input  logic signed [W-1:0]   zi,
  input  logic signed [W-1:0]   xj,
  input  logic signed [W-1:0]   yj,
  input  logic signed [W-1:0]   zj,
  output logic        [2*W-1:0] r2
);
  import neighbor_scan_ctrl_pkg::*;

  logic signed [W-1:0]   dx, dy, dz;
  logic signed [2*W-1:0] ex, ey, ez;
  logic signed [2*W-1:0] sx, sy, sz;

  always_comb begin
    dx = xj - xi;
    dy = yj - yi;
    dz = zj - zi;
    ex = (2*W)'(dx);
    ey = (2*W)'(dy);
    ez = (2*W)'(dz);
    sx = ex * ex;
    sy = ey * ey;
    sz = ez * ez;
    r2 = $unsigned(sx) + $unsigned(sy) + $unsigned(sz);
  end

endmodule

// File: rtl/neighbor_scan_ctrl.sv
// Pair-walking sequencer: reads atom positions, tests each pair against rcut2, streams accepted pairs.
// Define FINGERPRINT_FULL_LIST_EN to emit every ordered pair (i != j) instead of each unordered pair once.
module neighbor_scan_ctrl #(
  parameter int IDX_W  = 10,
  parameter int QWIDTH = neighbor_scan_ctrl_pkg::QWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W:0]    n_atoms,
  input  logic [63:0]       rcut2,
  output logic              pos_rd_en,
  output logic [IDX_W-1:0]  pos_addr,
  input  logic [QWIDTH-1:0] pos_x,
  input  logic [QWIDTH-1:0] pos_y,
  input  logic [QWIDTH-1:0] pos_z,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [IDX_W-1:0]  pair_i,
  output logic [IDX_W-1:0]  pair_j,
  output logic [63:0]       pair_r2,
  output logic              busy,
  output logic              done
);
  import neighbor_scan_ctrl_pkg::*;

  localparam int CW = IDX_W + 2;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [IDX_W:0] idx_t;

  state_t            state_q, state_d;
  idx_t              i_q, i_d, j_q, j_d, n_q, n_d;
  logic [63:0]       rcut2_q, rcut2_d;
  logic [QWIDTH-1:0] xi_q, xi_d, yi_q, yi_d, zi_q, zi_d;
  logic              pos_rd_en_q, pos_rd_en_d;
  logic [IDX_W-1:0]  pos_addr_q, pos_addr_d;
  logic              pair_valid_q, pair_valid_d;
  logic [IDX_W-1:0]  pair_i_q, pair_i_d, pair_j_q, pair_j_d;
  logic [63:0]       pair_r2_q, pair_r2_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [63:0]       r2;

  cnt_t              i_ext, j_ext, n_ext, j_next;
  idx_t              i_inc, first_j;
  logic              j_more, i_more;
  state_t            adv_state;
  idx_t              adv_i, adv_j;

  neighbor_scan_ctrl_dist_sq #(
    .W(QWIDTH)
  ) u_dist_sq (
    .xi(xi_q),
    .yi(yi_q),
    .zi(zi_q),
    .xj(pos_x),
    .yj(pos_y),
    .zj(pos_z),
    .r2(r2)
  );

  // Next (i, j) after the current pair; counters carry spare bits so j can step past n.
  always_comb begin
    i_ext = cnt_t'(i_q);
    j_ext = cnt_t'(j_q);
    n_ext = cnt_t'(n_q);
    i_inc = i_q + idx_t'(1);
`ifdef FINGERPRINT_FULL_LIST_EN
    first_j = (i_q == '0) ? idx_t'(1) : '0;
    j_next  = ((j_ext + cnt_t'(1)) == i_ext) ? (j_ext + cnt_t'(2)) : (j_ext + cnt_t'(1));
    i_more  = (i_ext + cnt_t'(1)) < n_ext;
`else
    first_j = i_inc;
    j_next  = j_ext + cnt_t'(1);
    i_more  = (i_ext + cnt_t'(2)) < n_ext;
`endif
    j_more    = j_next < n_ext;
    adv_i     = i_q;
    adv_j     = j_q;
    adv_state = ST_DONE;
    if (j_more) begin
      adv_state = ST_FETCH_J;
      adv_j     = j_next[IDX_W:0];
    end else if (i_more) begin
      adv_state = ST_FETCH_I;
      adv_i     = i_inc;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    n_d          = n_q;
    rcut2_d      = rcut2_q;
    xi_d         = xi_q;
    yi_d         = yi_q;
    zi_d         = zi_q;
    pair_i_d     = pair_i_q;
    pair_j_d     = pair_j_q;
    pair_r2_d    = pair_r2_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_atoms >= idx_t'(2)) begin
            n_d     = n_atoms;
            rcut2_d = rcut2;
            i_d     = '0;
            state_d = ST_FETCH_I;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH_I: state_d = ST_LATCH_I;
      ST_LATCH_I: begin
        xi_d    = pos_x;
        yi_d    = pos_y;
        zi_d    = pos_z;
        j_d     = first_j;
        state_d = ST_FETCH_J;
      end
      ST_FETCH_J: state_d = ST_EVAL;
      ST_EVAL: begin
        pair_r2_d = r2;
        pair_i_d  = i_q[IDX_W-1:0];
        pair_j_d  = j_q[IDX_W-1:0];
        if (r2 < rcut2_q) begin
          state_d = ST_EMIT;
        end else begin
          state_d = adv_state;
          i_d     = adv_i;
          j_d     = adv_j;
        end
      end
      ST_EMIT: begin
        if (pair_ready) begin
          state_d = adv_state;
          i_d     = adv_i;
          j_d     = adv_j;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    pos_rd_en_d  = (state_d == ST_FETCH_I) || (state_d == ST_FETCH_J);
    pos_addr_d   = pos_addr_q;
    if (state_d == ST_FETCH_I) begin
      pos_addr_d = i_d[IDX_W-1:0];
    end else if (state_d == ST_FETCH_J) begin
      pos_addr_d = j_d[IDX_W-1:0];
    end
    pair_valid_d = (state_d == ST_EMIT);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      n_q          <= '0;
      rcut2_q      <= '0;
      xi_q         <= '0;
      yi_q         <= '0;
      zi_q         <= '0;
      pos_rd_en_q  <= 1'b0;
      pos_addr_q   <= '0;
      pair_valid_q <= 1'b0;
      pair_i_q     <= '0;
      pair_j_q     <= '0;
      pair_r2_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      n_q          <= n_d;
      rcut2_q      <= rcut2_d;
      xi_q         <= xi_d;
      yi_q         <= yi_d;
      zi_q         <= zi_d;
      pos_rd_en_q  <= pos_rd_en_d;
      pos_addr_q   <= pos_addr_d;
      pair_valid_q <= pair_valid_d;
      pair_i_q     <= pair_i_d;
      pair_j_q     <= pair_j_d;
      pair_r2_q    <= pair_r2_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pos_rd_en  = pos_rd_en_q;
  assign pos_addr   = pos_addr_q;
  assign pair_valid = pair_valid_q;
  assign pair_i     = pair_i_q;
  assign pair_j     = pair_j_q;
  assign pair_r2    = pair_r2_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_neighbor_scan_ctrl.sv
// Self-checking bench for neighbor_scan_ctrl: directed table, random scans against a pair-list model,
// and hand-written sequences for start-while-busy and reset mid-emit. Honours FINGERPRINT_FULL_LIST_EN.
`timescale 1ns/1ps
module tb_neighbor_scan_ctrl;

  localparam int IDX_W = 10;
`ifdef FINGERPRINT_FULL_LIST_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W:0]   n_atoms = '0;
  logic [63:0]      rcut2 = '0;
  logic             pos_rd_en;
  logic [IDX_W-1:0] pos_addr;
  logic [31:0]      pos_x = '0, pos_y = '0, pos_z = '0;
  logic             pair_valid;
  logic             pair_ready = 1'b1;
  logic [IDX_W-1:0] pair_i, pair_j;
  logic [63:0]      pair_r2;
  logic             busy, done;

  always #5 clk = ~clk;

  neighbor_scan_ctrl #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_atoms(n_atoms), .rcut2(rcut2),
    .pos_rd_en(pos_rd_en), .pos_addr(pos_addr), .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_i(pair_i), .pair_j(pair_j),
    .pair_r2(pair_r2), .busy(busy), .done(done)
  );

  logic [31:0] mem_x [16];
  logic [31:0] mem_y [16];
  logic [31:0] mem_z [16];

  // Position RAM with one cycle of read latency
  always @(posedge clk) begin
    if (pos_rd_en) begin
      pos_x <= mem_x[pos_addr[3:0]];
      pos_y <= mem_y[pos_addr[3:0]];
      pos_z <= mem_z[pos_addr[3:0]];
    end
  end

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [63:0]      r2;
  } pair_t;

  pair_t got_q[$];
  pair_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0, rd_count = 0, done_count = 0, done_cyc = 0, stall_errs = 0;
  bit prev_v = 1'b0, prev_r = 1'b0;
  pair_t prev_p;

  bit ready_rand = 1'b0;
  bit ready_level = 1'b1;

  initial forever begin
    @(posedge clk);
    #1;
    pair_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Observe the pair stream, RAM reads and done pulses away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r && (!pair_valid || ({pair_i, pair_j, pair_r2} != prev_p)))
        stall_errs = stall_errs + 1;
      if (pair_valid && pair_ready) got_q.push_back({pair_i, pair_j, pair_r2});
      if (pos_rd_en) rd_count = rd_count + 1;
      if (done) begin
        done_count = done_count + 1;
        done_cyc   = cyc;
      end
      prev_v = pair_valid;
      prev_r = pair_ready;
      prev_p = {pair_i, pair_j, pair_r2};
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] model_r2(input int a, input int b);
    logic [31:0] dx, dy, dz;
    longint sx, sy, sz;
    dx = mem_x[b] - mem_x[a];
    dy = mem_y[b] - mem_y[a];
    dz = mem_z[b] - mem_z[a];
    sx = longint'($signed(dx));
    sy = longint'($signed(dy));
    sz = longint'($signed(dz));
    return 64'(sx * sx) + 64'(sy * sy) + 64'(sz * sz);
  endfunction

  // Expected pair list straight from the pair-set definition; ni counts i values that have any j
  task automatic build_model(input int n, input logic [63:0] rc, output int evals, output int ni);
    bit any;
    pair_t p;
    exp_q.delete();
    evals = 0;
    ni = 0;
    for (int i = 0; i < n; i++) begin
      any = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (FULL ? (j == i) : (j <= i)) continue;
        any = 1'b1;
        evals++;
        p.i  = IDX_W'(i);
        p.j  = IDX_W'(j);
        p.r2 = model_r2(i, j);
        if (p.r2 < rc) exp_q.push_back(p);
      end
      if (any) ni++;
    end
  endtask

  task automatic applyStimulus(input int n, input logic [63:0] rc, output int lat);
    int t0, d0;
    bit seen;
    got_q.delete();
    @(posedge clk);
    #1;
    start = 1'b1;
    n_atoms = (IDX_W+1)'(n);
    rcut2 = rc;
    d0 = done_count;
    rd_count = 0;
    @(posedge clk);
    t0 = cyc;
    #1;
    start = 1'b0;
    checkOutput("busy_rise", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(posedge clk);
      if (done_count != d0) seen = 1'b1;
    end
    checkOutput("done_timeout", 64'(seen), 64'd1);
    #1;
    checkOutput("busy_fall", 64'(busy), 64'd0);
    lat = done_cyc - t0;
    repeat (3) @(posedge clk);
    checkOutput("done_once", 64'(done_count - d0), 64'd1);
  endtask

  task automatic compareQueues(input string tag);
    int m;
    checkOutput({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      checkOutput({tag, "_pair_ij"}, 64'({got_q[k].i, got_q[k].j}), 64'({exp_q[k].i, exp_q[k].j}));
      checkOutput({tag, "_pair_r2"}, got_q[k].r2, exp_q[k].r2);
    end
  endtask

  typedef struct {
    int          n;
    logic [63:0] rc;
    int          xs[4];
    int          exp_pairs;
    logic [63:0] exp_r2;
    bit          rr;
  } vec_t;

  vec_t vecs[6];

  task automatic setVec(input int idx, input int n, input logic [63:0] rc,
                        input int x0, input int x1, input int x2, input int x3,
                        input int ep, input logic [63:0] er2, input bit rr);
    vecs[idx].n = n;
    vecs[idx].rc = rc;
    vecs[idx].xs[0] = x0;
    vecs[idx].xs[1] = x1;
    vecs[idx].xs[2] = x2;
    vecs[idx].xs[3] = x3;
    vecs[idx].exp_pairs = ep;
    vecs[idx].exp_r2 = er2;
    vecs[idx].rr = rr;
  endtask

  task automatic load_units(input int x0, input int x1, input int x2, input int x3);
    int xs[4];
    xs = '{x0, x1, x2, x3};
    for (int k = 0; k < 16; k++) begin
      mem_x[k] = (k < 4) ? (32'(xs[k]) << 16) : 32'd0;
      mem_y[k] = '0;
      mem_z[k] = '0;
    end
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (pair_valid) seen = 1'b1;
    end
    checkOutput({tag, "_valid_timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int d0;
    bit seen;
    d0 = done_count;
    seen = 1'b0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(posedge clk);
      if (done_count != d0) seen = 1'b1;
    end
    checkOutput({tag, "_done_timeout"}, 64'(seen), 64'd1);
  endtask

  initial begin
    int lat, evals, ni, rd_snap, a, b, n;
    logic [63:0] rc;
    logic [63:0] ones;
    ones = '1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pair_valid", 64'(pair_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pos_rd_en", 64'(pos_rd_en), 64'd0);
    checkOutput("rst_pos_addr", 64'(pos_addr), 64'd0);
    checkOutput("rst_pair_i", 64'(pair_i), 64'd0);
    checkOutput("rst_pair_j", 64'(pair_j), 64'd0);
    checkOutput("rst_pair_r2", pair_r2, 64'd0);
    rst_n = 1'b1;

    setVec(0, 3, 64'h4_0000_0000, 0, 1, 3, 0, FULL ? 2 : 1, 64'h1_0000_0000, 1'b0);
    setVec(1, 0, ones, 0, 0, 0, 0, 0, 64'd0, 1'b0);
    setVec(2, 1, ones, 0, 0, 0, 0, 0, 64'd0, 1'b0);
    setVec(3, 2, ones, -32768, 32767, 0, 0, FULL ? 2 : 1, 64'h1_0000_0000, 1'b0);
    setVec(4, 4, 64'd1, 5, 5, 5, 5, FULL ? 12 : 6, 64'd0, 1'b1);
    setVec(5, 4, 64'd0, 5, 5, 5, 5, 0, 64'd0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      load_units(vecs[v].xs[0], vecs[v].xs[1], vecs[v].xs[2], vecs[v].xs[3]);
      ready_rand = vecs[v].rr;
      ready_level = 1'b1;
      stall_errs = 0;
      build_model(vecs[v].n, vecs[v].rc, evals, ni);
      applyStimulus(vecs[v].n, vecs[v].rc, lat);
      checkOutput($sformatf("vec%0d_table_count", v), 64'(got_q.size()), 64'(vecs[v].exp_pairs));
      if (vecs[v].exp_pairs > 0 && got_q.size() > 0) begin
        checkOutput($sformatf("vec%0d_first_ij", v), 64'({got_q[0].i, got_q[0].j}), 64'({10'd0, 10'd1}));
        checkOutput($sformatf("vec%0d_first_r2", v), got_q[0].r2, vecs[v].exp_r2);
      end
      compareQueues($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_reads", v), 64'(rd_count), 64'(ni + evals));
      if (!vecs[v].rr)
        checkOutput($sformatf("vec%0d_latency", v), 64'(lat), 64'(2*ni + 2*evals + exp_q.size() + 1));
      checkOutput($sformatf("vec%0d_stall_stable", v), 64'(stall_errs), 64'd0);
    end

    // Random scans with random backpressure; cutoffs often sit exactly on a pair's r2
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(2, 8);
      for (int k = 0; k < 16; k++) begin
        mem_x[k] = ((32'($urandom_range(0, 15)) - 32'd8) << 16) | 32'($urandom_range(0, 65535));
        mem_y[k] = ((32'($urandom_range(0, 15)) - 32'd8) << 16) | 32'($urandom_range(0, 65535));
        mem_z[k] = ((32'($urandom_range(0, 15)) - 32'd8) << 16) | 32'($urandom_range(0, 65535));
        if ($urandom_range(0, 9) == 0) mem_x[k] = $urandom();
      end
      a = $urandom_range(0, n - 1);
      b = (a + 1 + $urandom_range(0, n - 2)) % n;
      case ($urandom_range(0, 2))
        0: rc = model_r2(a, b);
        1: rc = model_r2(a, b) + 64'd1;
        default: rc = {26'd0, 6'($urandom_range(0, 63)), 32'($urandom())};
      endcase
      ready_rand = 1'b1;
      stall_errs = 0;
      build_model(n, rc, evals, ni);
      applyStimulus(n, rc, lat);
      compareQueues($sformatf("rand%0d", it));
      checkOutput($sformatf("rand%0d_reads", it), 64'(rd_count), 64'(ni + evals));
      checkOutput($sformatf("rand%0d_stall_stable", it), 64'(stall_errs), 64'd0);
    end

    // A second start while stalled in EMIT must neither restart nor disturb the scan
    load_units(5, 5, 5, 5);
    ready_rand = 1'b0;
    ready_level = 1'b0;
    stall_errs = 0;
    got_q.delete();
    @(posedge clk);
    #1;
    start = 1'b1;
    n_atoms = 11'd4;
    rcut2 = 64'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid("busy_start");
    rd_snap = rd_count;
    start = 1'b1;
    n_atoms = 11'd2;
    rcut2 = 64'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("stall_valid_held", 64'(pair_valid), 64'd1);
    checkOutput("stall_pair_ij", 64'({pair_i, pair_j}), 64'({10'd0, 10'd1}));
    checkOutput("stall_pair_r2", pair_r2, 64'd0);
    checkOutput("stall_busy", 64'(busy), 64'd1);
    checkOutput("stall_no_reads", 64'(rd_count), 64'(rd_snap));
    ready_level = 1'b1;
    wait_done("busy_start");
    build_model(4, 64'd1, evals, ni);
    compareQueues("busy_start");
    checkOutput("busy_start_stall_stable", 64'(stall_errs), 64'd0);

    // One cycle of reset mid-EMIT discards the scan; the next start runs cleanly
    ready_level = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    n_atoms = 11'd4;
    rcut2 = 64'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid("mid_reset");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("mid_reset_valid", 64'(pair_valid), 64'd0);
    checkOutput("mid_reset_busy", 64'(busy), 64'd0);
    checkOutput("mid_reset_rd_en", 64'(pos_rd_en), 64'd0);
    checkOutput("mid_reset_r2", pair_r2, 64'd0);
    ready_level = 1'b1;
    load_units(0, 1, 3, 0);
    stall_errs = 0;
    build_model(3, 64'h4_0000_0000, evals, ni);
    applyStimulus(3, 64'h4_0000_0000, lat);
    compareQueues("after_reset");
    checkOutput("after_reset_latency", 64'(lat), 64'(2*ni + 2*evals + exp_q.size() + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
